// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: turns TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB into single-cycle
// port transactions on the TLB array and returns one response per command.
module tlb_ctrl #(
    parameter int TLBNUM = 8,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [9:0]    csr_asid,
    input  logic [18:0]   csr_vppn,
    input  logic [IW-1:0] csr_index,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic          csr_refill,
    input  logic [27:0]   csr_elo0,
    input  logic [27:0]   csr_elo1,
    input  logic [4:0]    cmd_inv_op,
    input  logic [9:0]    cmd_inv_asid,
    input  logic [18:0]   cmd_inv_vpn,
    output logic          rsp_valid,
    output logic [2:0]    rsp_op,
    output logic          rsp_err,
    output logic          rsp_found,
    output logic [IW-1:0] rsp_index,
    output logic          rsp_ne,
    output logic [18:0]   rsp_vppn,
    output logic [9:0]    rsp_asid,
    output logic [5:0]    rsp_ps,
    output logic [27:0]   rsp_elo0,
    output logic [27:0]   rsp_elo1,
    output logic          s1_fetch,
    output logic [18:0]   s1_vppn,
    output logic          s1_odd_page,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vppn,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [5:0]    w_ps,
    output logic          w_e,
    output logic          w_v0,
    output logic          w_d0,
    output logic [1:0]    w_mat0,
    output logic [1:0]    w_plv0,
    output logic [19:0]   w_ppn0,
    output logic          w_v1,
    output logic          w_d1,
    output logic [1:0]    w_mat1,
    output logic [1:0]    w_plv1,
    output logic [19:0]   w_ppn1,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [5:0]    r_ps,
    input  logic          r_v0,
    input  logic          r_d0,
    input  logic [1:0]    r_mat0,
    input  logic [1:0]    r_plv0,
    input  logic [19:0]   r_ppn0,
    input  logic          r_v1,
    input  logic          r_d1,
    input  logic [1:0]    r_mat1,
    input  logic [1:0]    r_plv1,
    input  logic [19:0]   r_ppn1,
    output logic          inv_en,
    output logic [4:0]    inv_op,
    output logic [9:0]    inv_asid,
    output logic [18:0]   inv_vpn
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
    localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

    state_t        state_q, state_d;
    logic [IW-1:0] fill_ctr_q, fill_ctr_d, idx_q, idx_d, rsp_index_q, rsp_index_d;
    logic [2:0]    op_q, op_d, rsp_op_q, rsp_op_d;
    logic [18:0]   vppn_q, vppn_d, ivpn_q, ivpn_d, rsp_vppn_q, rsp_vppn_d;
    logic [9:0]    asid_q, asid_d, iasid_q, iasid_d, rsp_asid_q, rsp_asid_d;
    logic [5:0]    ps_q, ps_d, rsp_ps_q, rsp_ps_d;
    logic [26:0]   elo0_q, elo0_d, elo1_q, elo1_d;
    logic [27:0]   rsp_elo0_q, rsp_elo0_d, rsp_elo1_q, rsp_elo1_d;
    logic [4:0]    iop_q, iop_d;
    logic          w_e_q, w_e_d, we_q, we_d, inv_en_q, inv_en_d, s1_fetch_q, s1_fetch_d;
    logic          rsp_err_q, rsp_err_d, rsp_found_q, rsp_found_d, rsp_ne_q, rsp_ne_d;

    // Bit 27 of the ELO operands carries no field.
    logic unused_elo_msb;
    assign unused_elo_msb = csr_elo0[27] ^ csr_elo1[27];

    always_comb begin
        state_d     = state_q;
        fill_ctr_d  = fill_ctr_q + IW'(1);
        op_d        = op_q;
        idx_d       = idx_q;
        vppn_d      = vppn_q;
        asid_d      = asid_q;
        ps_d        = ps_q;
        elo0_d      = elo0_q;
        elo1_d      = elo1_q;
        iop_d       = iop_q;
        iasid_d     = iasid_q;
        ivpn_d      = ivpn_q;
        w_e_d       = w_e_q;
        we_d        = 1'b0;
        inv_en_d    = 1'b0;
        s1_fetch_d  = 1'b0;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        rsp_found_d = rsp_found_q;
        rsp_index_d = rsp_index_q;
        rsp_ne_d    = rsp_ne_q;
        rsp_vppn_d  = rsp_vppn_q;
        rsp_asid_d  = rsp_asid_q;
        rsp_ps_d    = rsp_ps_q;
        rsp_elo0_d  = rsp_elo0_q;
        rsp_elo1_d  = rsp_elo1_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = EXEC;
                    op_d       = cmd_op;
                    idx_d      = (cmd_op == OP_FILL) ? fill_ctr_q : csr_index;
                    vppn_d     = csr_vppn;
                    asid_d     = csr_asid;
                    ps_d       = csr_ps;
                    elo0_d     = csr_elo0[26:0];
                    elo1_d     = csr_elo1[26:0];
                    iop_d      = cmd_inv_op;
                    iasid_d    = cmd_inv_asid;
                    ivpn_d     = cmd_inv_vpn;
                    w_e_d      = csr_refill | ~csr_ne;
                    // Port strobes are registered here so they are high exactly during EXEC.
                    we_d       = (cmd_op == OP_WR) || (cmd_op == OP_FILL);
                    inv_en_d   = (cmd_op == OP_INV) && (cmd_inv_op <= 5'd6);
                    s1_fetch_d = (cmd_op == OP_SRCH);
                end
            end
            EXEC: begin
                rsp_op_d    = op_q;
                rsp_err_d   = (op_q > OP_INV) || ((op_q == OP_INV) && (iop_q > 5'd6));
                rsp_found_d = 1'b0;
                rsp_ne_d    = 1'b0;
                if (op_q == OP_RD) begin
                    if (r_e) begin
                        rsp_vppn_d = r_vppn;
                        rsp_asid_d = r_asid;
                        rsp_ps_d   = r_ps;
                        rsp_elo0_d = {1'b0, r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                        rsp_elo1_d = {1'b0, r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1};
                    end else begin
                        rsp_ne_d   = 1'b1;
                        rsp_vppn_d = '0;
                        rsp_asid_d = '0;
                        rsp_ps_d   = '0;
                        rsp_elo0_d = '0;
                        rsp_elo1_d = '0;
                    end
                end
                state_d = (op_q == OP_SRCH) ? WAIT : RESP;
            end
            WAIT: begin
                rsp_found_d = s1_found;
                rsp_index_d = s1_index;
                rsp_ne_d    = ~s1_found;
                state_d     = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_ctr_q  <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            vppn_q      <= '0;
            asid_q      <= '0;
            ps_q        <= '0;
            elo0_q      <= '0;
            elo1_q      <= '0;
            iop_q       <= '0;
            iasid_q     <= '0;
            ivpn_q      <= '0;
            w_e_q       <= 1'b0;
            we_q        <= 1'b0;
            inv_en_q    <= 1'b0;
            s1_fetch_q  <= 1'b0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_ne_q    <= 1'b0;
            rsp_vppn_q  <= '0;
            rsp_asid_q  <= '0;
            rsp_ps_q    <= '0;
            rsp_elo0_q  <= '0;
            rsp_elo1_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_ctr_q  <= fill_ctr_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            vppn_q      <= vppn_d;
            asid_q      <= asid_d;
            ps_q        <= ps_d;
            elo0_q      <= elo0_d;
            elo1_q      <= elo1_d;
            iop_q       <= iop_d;
            iasid_q     <= iasid_d;
            ivpn_q      <= ivpn_d;
            w_e_q       <= w_e_d;
            we_q        <= we_d;
            inv_en_q    <= inv_en_d;
            s1_fetch_q  <= s1_fetch_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            rsp_found_q <= rsp_found_d;
            rsp_index_q <= rsp_index_d;
            rsp_ne_q    <= rsp_ne_d;
            rsp_vppn_q  <= rsp_vppn_d;
            rsp_asid_q  <= rsp_asid_d;
            rsp_ps_q    <= rsp_ps_d;
            rsp_elo0_q  <= rsp_elo0_d;
            rsp_elo1_q  <= rsp_elo1_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_op      = rsp_op_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_found   = rsp_found_q;
    assign rsp_index   = rsp_index_q;
    assign rsp_ne      = rsp_ne_q;
    assign rsp_vppn    = rsp_vppn_q;
    assign rsp_asid    = rsp_asid_q;
    assign rsp_ps      = rsp_ps_q;
    assign rsp_elo0    = rsp_elo0_q;
    assign rsp_elo1    = rsp_elo1_q;
    assign s1_fetch    = s1_fetch_q;
    assign s1_vppn     = vppn_q;
    assign s1_odd_page = 1'b0;
    assign s1_asid     = asid_q;
    // ELO layout: {ppn[26:7], g[6], mat[5:4], plv[3:2], d[1], v[0]}.
    assign we          = we_q;
    assign w_index     = idx_q;
    assign w_vppn      = vppn_q;
    assign w_asid      = asid_q;
    assign w_g         = elo0_q[6] & elo1_q[6];
    assign w_ps        = ps_q;
    assign w_e         = w_e_q;
    assign w_v0        = elo0_q[0];
    assign w_d0        = elo0_q[1];
    assign w_plv0      = elo0_q[3:2];
    assign w_mat0      = elo0_q[5:4];
    assign w_ppn0      = elo0_q[26:7];
    assign w_v1        = elo1_q[0];
    assign w_d1        = elo1_q[1];
    assign w_plv1      = elo1_q[3:2];
    assign w_mat1      = elo1_q[5:4];
    assign w_ppn1      = elo1_q[26:7];
    assign r_index     = idx_q;
    assign inv_en      = inv_en_q;
    assign inv_op      = iop_q;
    assign inv_asid    = iasid_q;
    assign inv_vpn     = ivpn_q;
endmodule

// File: tb/tb_tlb_ctrl.sv
// Table-driven bench for tlb_ctrl with a small behavioural TLB array behind the ports.
module tb_tlb_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic cmd_valid = 0, cmd_ready;
    logic [2:0] cmd_op = 0;
    logic [9:0] csr_asid = 0, cmd_inv_asid = 0;
    logic [18:0] csr_vppn = 0, cmd_inv_vpn = 0;
    logic [2:0] csr_index = 0;
    logic [5:0] csr_ps = 0;
    logic csr_ne = 0, csr_refill = 0;
    logic [27:0] csr_elo0 = 0, csr_elo1 = 0;
    logic [4:0] cmd_inv_op = 0;
    logic rsp_valid, rsp_err, rsp_found, rsp_ne;
    logic [2:0] rsp_op, rsp_index;
    logic [18:0] rsp_vppn;
    logic [9:0] rsp_asid;
    logic [5:0] rsp_ps;
    logic [27:0] rsp_elo0, rsp_elo1;
    logic s1_fetch, s1_odd_page, s1_found;
    logic [18:0] s1_vppn;
    logic [9:0] s1_asid;
    logic [2:0] s1_index, w_index, r_index;
    logic we, w_g, w_e, w_v0, w_d0, w_v1, w_d1;
    logic [18:0] w_vppn, inv_vpn;
    logic [9:0] w_asid, inv_asid;
    logic [5:0] w_ps;
    logic [1:0] w_mat0, w_plv0, w_mat1, w_plv1;
    logic [19:0] w_ppn0, w_ppn1;
    logic r_e, r_g, r_v0, r_d0, r_v1, r_d1;
    logic [18:0] r_vppn;
    logic [9:0] r_asid;
    logic [5:0] r_ps;
    logic [1:0] r_mat0, r_plv0, r_mat1, r_plv1;
    logic [19:0] r_ppn0, r_ppn1;
    logic inv_en;
    logic [4:0] inv_op;

    tlb_ctrl #(.TLBNUM(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index), .csr_ps(csr_ps),
        .csr_ne(csr_ne), .csr_refill(csr_refill), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .cmd_inv_op(cmd_inv_op), .cmd_inv_asid(cmd_inv_asid), .cmd_inv_vpn(cmd_inv_vpn),
        .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_found(rsp_found),
        .rsp_index(rsp_index), .rsp_ne(rsp_ne), .rsp_vppn(rsp_vppn), .rsp_asid(rsp_asid),
        .rsp_ps(rsp_ps), .rsp_elo0(rsp_elo0), .rsp_elo1(rsp_elo1),
        .s1_fetch(s1_fetch), .s1_vppn(s1_vppn), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_vppn(w_vppn), .w_asid(w_asid), .w_g(w_g), .w_ps(w_ps),
        .w_e(w_e), .w_v0(w_v0), .w_d0(w_d0), .w_mat0(w_mat0), .w_plv0(w_plv0), .w_ppn0(w_ppn0),
        .w_v1(w_v1), .w_d1(w_d1), .w_mat1(w_mat1), .w_plv1(w_plv1), .w_ppn1(w_ppn1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g), .r_ps(r_ps),
        .r_v0(r_v0), .r_d0(r_d0), .r_mat0(r_mat0), .r_plv0(r_plv0), .r_ppn0(r_ppn0),
        .r_v1(r_v1), .r_d1(r_d1), .r_mat1(r_mat1), .r_plv1(r_plv1), .r_ppn1(r_ppn1),
        .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn)
    );

    // Behavioural TLB array: write on we, one-cycle search on s1_fetch, combinational read.
    logic m_e[8], m_g[8];
    logic [18:0] m_vppn[8];
    logic [9:0] m_asid[8];
    logic [5:0] m_ps[8];
    logic [25:0] m_lo0[8], m_lo1[8];
    always @(posedge clk) begin : tlb_model
        logic hit;
        logic [2:0] hidx;
        if (reset) begin
            for (int k = 0; k < 8; k++) m_e[k] <= 1'b0;
            s1_found <= 1'b0;
            s1_index <= 3'd0;
        end else begin
            if (we) begin
                m_e[w_index] <= w_e;
                m_g[w_index] <= w_g;
                m_vppn[w_index] <= w_vppn;
                m_asid[w_index] <= w_asid;
                m_ps[w_index] <= w_ps;
                m_lo0[w_index] <= {w_ppn0, w_mat0, w_plv0, w_d0, w_v0};
                m_lo1[w_index] <= {w_ppn1, w_mat1, w_plv1, w_d1, w_v1};
            end
            hit = 1'b0;
            hidx = 3'd0;
            for (int k = 0; k < 8; k++)
                if (m_e[k] && m_vppn[k] == s1_vppn && (m_g[k] || m_asid[k] == s1_asid)) begin
                    hit = 1'b1;
                    hidx = 3'(k);
                end
            s1_found <= s1_fetch & hit;
            s1_index <= hidx;
        end
    end
    assign r_e = m_e[r_index];
    assign r_g = m_g[r_index];
    assign r_vppn = m_vppn[r_index];
    assign r_asid = m_asid[r_index];
    assign r_ps = m_ps[r_index];
    assign {r_ppn0, r_mat0, r_plv0, r_d0, r_v0} = m_lo0[r_index];
    assign {r_ppn1, r_mat1, r_plv1, r_d1, r_v1} = m_lo1[r_index];

    // Reference fill counter: counts every cycle from 0 after reset.
    logic [2:0] ref_ctr;
    always @(posedge clk or posedge reset)
        if (reset) ref_ctr <= 3'd0; else ref_ctr <= ref_ctr + 3'd1;

    int we_cnt = 0, inv_cnt = 0, s1_cnt = 0, rsp_cnt = 0;
    always @(posedge clk) begin
        we_cnt <= we_cnt + int'(we);
        inv_cnt <= inv_cnt + int'(inv_en);
        s1_cnt <= s1_cnt + int'(s1_fetch);
        rsp_cnt <= rsp_cnt + int'(rsp_valid);
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    localparam logic [19:0] PPN0 = 20'hABCDE, PPN1 = 20'h13579;
    function automatic logic [27:0] elo0_of(input logic g);
        return {1'b0, PPN0, g, 2'b01, 2'b11, 1'b1, 1'b1};
    endfunction
    function automatic logic [27:0] elo1_of(input logic g);
        return {1'b0, PPN1, g, 2'b10, 2'b01, 1'b0, 1'b1};
    endfunction

    typedef struct {
        logic [2:0] op; logic [2:0] idx; logic [18:0] vppn; logic [9:0] asid; logic [5:0] ps;
        logic ne; logic refill; logic g; logic [4:0] iop;
        int lat; logic err; int nwe; int ninv; int ns1; logic we_e;
        logic found; logic rne; logic [2:0] ridx; logic [18:0] rvppn; logic [9:0] rasid;
    } vec_t;
    vec_t vt[18];

    task automatic run_vec(input int i);
        vec_t v;
        int lat, we0, inv0, s10, rsp0;
        v = vt[i];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v.op != 3'd3 || ref_ctr == v.idx) break;
        end
        cmd_op = v.op; csr_index = v.idx; csr_vppn = v.vppn; csr_asid = v.asid; csr_ps = v.ps;
        csr_ne = v.ne; csr_refill = v.refill; csr_elo0 = elo0_of(v.g); csr_elo1 = elo1_of(v.g);
        cmd_inv_op = v.iop; cmd_inv_asid = v.asid; cmd_inv_vpn = v.vppn;
        we0 = we_cnt; inv0 = inv_cnt; s10 = s1_cnt; rsp0 = rsp_cnt;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble operands so that only the values latched at acceptance can show up.
        cmd_valid = 1'b0; cmd_op = 3'd7; csr_index = ~v.idx; csr_vppn = ~v.vppn; csr_asid = ~v.asid;
        csr_ne = ~v.ne; csr_refill = ~v.refill; csr_elo0 = ~csr_elo0; cmd_inv_op = 5'd0;
        chk($sformatf("v%0d ready_busy", i), cmd_ready, 0);
        chk($sformatf("v%0d we", i), we, v.nwe);
        chk($sformatf("v%0d inv_en", i), inv_en, v.ninv);
        chk($sformatf("v%0d s1_fetch", i), s1_fetch, v.ns1);
        if (v.nwe != 0) begin
            chk($sformatf("v%0d w_index", i), w_index, v.idx);
            chk($sformatf("v%0d w_e", i), w_e, v.we_e);
            chk($sformatf("v%0d w_vppn", i), w_vppn, v.vppn);
            chk($sformatf("v%0d w_asid", i), w_asid, v.asid);
            chk($sformatf("v%0d w_g", i), w_g, v.g);
        end
        if (v.ninv != 0) begin
            chk($sformatf("v%0d inv_op", i), inv_op, v.iop);
            chk($sformatf("v%0d inv_asid", i), inv_asid, v.asid);
        end
        if (v.ns1 != 0) begin
            chk($sformatf("v%0d s1_vppn", i), s1_vppn, v.vppn);
            chk($sformatf("v%0d s1_asid", i), s1_asid, v.asid);
        end
        lat = 1;
        while (!rsp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", i), lat, v.lat);
        chk($sformatf("v%0d rsp_op", i), rsp_op, v.op);
        chk($sformatf("v%0d rsp_err", i), rsp_err, v.err);
        if (v.op == 3'd0) begin
            chk($sformatf("v%0d rsp_found", i), rsp_found, v.found);
            chk($sformatf("v%0d rsp_ne", i), rsp_ne, v.rne);
            if (v.found) chk($sformatf("v%0d rsp_index", i), rsp_index, v.ridx);
        end
        if (v.op == 3'd1) begin
            chk($sformatf("v%0d rsp_ne", i), rsp_ne, v.rne);
            chk($sformatf("v%0d rsp_vppn", i), rsp_vppn, v.rvppn);
            chk($sformatf("v%0d rsp_asid", i), rsp_asid, v.rasid);
            chk($sformatf("v%0d rsp_ps", i), rsp_ps, v.ps);
            chk($sformatf("v%0d rsp_elo0", i), rsp_elo0, v.rne ? 28'd0 : elo0_of(v.g));
            chk($sformatf("v%0d rsp_elo1", i), rsp_elo1, v.rne ? 28'd0 : elo1_of(v.g));
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d rsp_one_cycle", i), rsp_valid, 0);
        chk($sformatf("v%0d ready_again", i), cmd_ready, 1);
        chk($sformatf("v%0d pulse_counts", i), {we_cnt - we0, inv_cnt - inv0, s1_cnt - s10, rsp_cnt - rsp0},
            {v.nwe, v.ninv, v.ns1, 1});
        $display("vec %0d op=%0d lat=%0d err=%0b found=%0b ne=%0b", i, v.op, lat, rsp_err, rsp_found, rsp_ne);
    endtask

    initial begin
        //        op idx vppn      asid   ps ne rf g iop lat err we inv s1 w_e fnd rne ridx rvppn    rasid
        vt[0]  = '{2, 3, 19'h12345, 10'h2A, 12, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[1]  = '{1, 3, 19'h0,     10'h0,  12, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 19'h12345, 10'h2A};
        vt[2]  = '{0, 0, 19'h12345, 10'h2A, 0,  0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 3, 0,         0};
        vt[3]  = '{0, 0, 19'h12345, 10'h2B, 0,  0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0,         0};
        vt[4]  = '{2, 5, 19'h00111, 10'h1,  14, 1, 1, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[5]  = '{2, 6, 19'h00222, 10'h2,  13, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0,         0};
        vt[6]  = '{1, 6, 19'h0,     10'h0,  0,  0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0,         0};
        vt[7]  = '{1, 5, 19'h0,     10'h0,  14, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 19'h00111, 10'h1};
        vt[8]  = '{2, 1, 19'h00444, 10'h7,  12, 0, 0, 1, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[9]  = '{0, 0, 19'h00444, 10'h9,  0,  0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 1, 0,         0};
        vt[10] = '{3, 5, 19'h00333, 10'h3,  12, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[11] = '{3, 7, 19'h00666, 10'h4,  12, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[12] = '{3, 0, 19'h00777, 10'h5,  12, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,         0};
        vt[13] = '{0, 0, 19'h00333, 10'h3,  0,  0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 5, 0,         0};
        vt[14] = '{1, 0, 19'h0,     10'h0,  12, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 19'h00777, 10'h5};
        vt[15] = '{4, 0, 19'h12345, 10'h2A, 0,  0, 0, 0, 4, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0,         0};
        vt[16] = '{4, 0, 19'h12345, 10'h2A, 0,  0, 0, 0, 9, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0,         0};
        vt[17] = '{6, 0, 19'h0,     10'h0,  0,  0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0,         0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset pulses", {we, inv_en, s1_fetch}, 0);
        chk("reset w_index", w_index, 0);
        chk("reset w_e", w_e, 0);
        chk("reset rsp_err", rsp_err, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(i);

        // Reset while a search sits in WAIT: nothing may surface afterwards.
        begin
            int rsp0, we0, s10;
            @(negedge clk);
            cmd_op = 3'd0; csr_vppn = 19'h12345; csr_asid = 10'h2A; cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(posedge clk); #1;
            rsp0 = rsp_cnt; we0 = we_cnt; s10 = s1_cnt;
            reset = 1'b1;
            #1;
            chk("midreset cmd_ready", cmd_ready, 1);
            chk("midreset rsp_valid", rsp_valid, 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("midreset no_rsp", rsp_cnt - rsp0, 0);
            chk("midreset no_pulse", (we_cnt - we0) + (s1_cnt - s10), 0);
            $display("midreset rsp_cnt_delta=%0d", rsp_cnt - rsp0);
        end
        // Fill counter restarted from 0: a FILL aimed at slot 2 must land there.
        vt[0] = '{3, 2, 19'h00888, 10'h6, 12, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
